// File: rtl/registrador_tiros_param.sv
// Shot-slot allocator: owns the per-slot loaded flags of the shot memory,
// finds a free slot (first-free or round-robin), writes the latched shot
// word into it and frees slots on request from collision/expiry logic.
module registrador_tiros_param #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 10,
    parameter int MODO_BUSCA = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    registra_tiro,
    input  logic [DATA_WIDTH-1:0]   dado_tiro,
    input  logic                    libera_tiro,
    input  logic [ADDR_WIDTH-1:0]   libera_endereco,
    output logic                    we_mem_tiro,
    output logic [ADDR_WIDTH-1:0]   endereco_mem_tiro,
    output logic [DATA_WIDTH-1:0]   dado_mem_tiro,
    output logic                    tiro_registrado,
    output logic                    tiro_rejeitado,
    output logic [ADDR_WIDTH-1:0]   endereco_tiro,
    output logic [2**ADDR_WIDTH-1:0] tiros_ativos,
    output logic [ADDR_WIDTH:0]     num_tiros,
    output logic                    ocupado,
    output logic [3:0]              db_estado
);

    localparam int N_TIROS = 2**ADDR_WIDTH;

    localparam logic [3:0] INICIAL  = 4'd0;
    localparam logic [3:0] ESPERA   = 4'd1;
    localparam logic [3:0] ZERA     = 4'd2;
    localparam logic [3:0] VERIFICA = 4'd3;
    localparam logic [3:0] SALVA    = 4'd5;
    localparam logic [3:0] SINALIZA = 4'd6;
    localparam logic [3:0] CHEIO    = 4'd8;

    logic [3:0]            estado;
    logic [3:0]            prox_estado;
    logic [ADDR_WIDTH-1:0] ptr_busca;
    logic [ADDR_WIDTH-1:0] ptr_rr;
    logic [ADDR_WIDTH-1:0] cont_busca;
    logic [ADDR_WIDTH-1:0] endereco_reg;
    logic [DATA_WIDTH-1:0] dado_reg;
    logic [N_TIROS-1:0]    ativos;
    logic [ADDR_WIDTH:0]   contagem;
    logic                  salva;
    logic                  libera_efetiva;
    logic                  ultimo_slot;

    assign salva          = (estado == SALVA);
    assign ultimo_slot    = (cont_busca == {ADDR_WIDTH{1'b1}});
    // A release only counts when the slot is actually loaded; during SALVA the
    // target slot is known free, so a same-slot release is naturally a no-op.
    assign libera_efetiva = libera_tiro && (estado != INICIAL) && ativos[libera_endereco];

    // Next-state logic of the allocation sequencer
    always_comb begin
        prox_estado = INICIAL;
        case (estado)
            INICIAL:  prox_estado = ESPERA;
            ESPERA:   prox_estado = registra_tiro ? ZERA : ESPERA;
            ZERA:     prox_estado = VERIFICA;
            VERIFICA: begin
                if (!ativos[ptr_busca])
                    prox_estado = SALVA;
                else if (ultimo_slot)
                    prox_estado = CHEIO;
                else
                    prox_estado = VERIFICA;
            end
            SALVA:    prox_estado = SINALIZA;
            SINALIZA: prox_estado = ESPERA;
            CHEIO:    prox_estado = ESPERA;
            default:  prox_estado = INICIAL;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            estado <= INICIAL;
        else
            estado <= prox_estado;
    end

    // Scan pointer, scan counter, round-robin pointer, latched word and result address
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_busca    <= '0;
            ptr_rr       <= '0;
            cont_busca   <= '0;
            dado_reg     <= '0;
            endereco_reg <= '0;
        end else begin
            case (estado)
                ESPERA: begin
                    if (registra_tiro)
                        dado_reg <= dado_tiro;
                end
                ZERA: begin
                    ptr_busca  <= (MODO_BUSCA != 0) ? ptr_rr : '0;
                    cont_busca <= '0;
                end
                VERIFICA: begin
                    if (ativos[ptr_busca] && !ultimo_slot) begin
                        ptr_busca  <= ptr_busca + 1'b1;
                        cont_busca <= cont_busca + 1'b1;
                    end
                end
                SALVA: begin
                    endereco_reg <= ptr_busca;
                    ptr_rr       <= ptr_busca + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Per-slot loaded flags; the SALVA set is applied last so it wins over a release
    always_ff @(posedge clock) begin
        if (reset) begin
            ativos <= '0;
        end else begin
            if (libera_efetiva)
                ativos[libera_endereco] <= 1'b0;
            if (salva)
                ativos[ptr_busca] <= 1'b1;
        end
    end

    // Occupancy up/down counter tracking the popcount of the loaded flags
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= '0;
        end else begin
            case ({salva, libera_efetiva})
                2'b10:   contagem <= contagem + 1'b1;
                2'b01:   contagem <= contagem - 1'b1;
                default: contagem <= contagem;
            endcase
        end
    end

    // Debug code: valid states report themselves, anything else reads as F
    always_comb begin
        db_estado = 4'hF;
        case (estado)
            INICIAL, ESPERA, ZERA, VERIFICA, SALVA, SINALIZA, CHEIO: db_estado = estado;
            default: db_estado = 4'hF;
        endcase
    end

    assign we_mem_tiro       = salva;
    assign endereco_mem_tiro = ptr_busca;
    assign dado_mem_tiro     = dado_reg;
    assign tiro_registrado   = (estado == SINALIZA);
    assign tiro_rejeitado    = (estado == CHEIO);
    assign endereco_tiro     = endereco_reg;
    assign tiros_ativos      = ativos;
    assign num_tiros         = contagem;
    assign ocupado           = (estado != ESPERA);

endmodule

// File: tb/tb_registrador_tiros_param.sv
// Directed bench for the shot-slot allocator: one instance in first-free
// mode and one in round-robin mode, each with its own inputs and reset.
module tb_registrador_tiros_param;

    logic       clock = 1'b0;
    logic       rst0, r0, l0;
    logic [9:0] d0;
    logic [2:0] la0;
    logic       we0, reg0, rej0, oc0;
    logic [2:0] ema0, et0;
    logic [9:0] dma0;
    logic [7:0] ta0;
    logic [3:0] nt0, db0;

    logic       rst1, r1, l1;
    logic [9:0] d1;
    logic [2:0] la1;
    logic       we1, reg1, rej1, oc1;
    logic [2:0] ema1, et1;
    logic [9:0] dma1;
    logic [7:0] ta1;
    logic [3:0] nt1, db1;

    int n_cmp  = 0;
    int n_fail = 0;
    int contador;

    registrador_tiros_param #(.ADDR_WIDTH(3), .DATA_WIDTH(10), .MODO_BUSCA(0)) dut0 (
        .clock(clock), .reset(rst0), .registra_tiro(r0), .dado_tiro(d0),
        .libera_tiro(l0), .libera_endereco(la0), .we_mem_tiro(we0),
        .endereco_mem_tiro(ema0), .dado_mem_tiro(dma0), .tiro_registrado(reg0),
        .tiro_rejeitado(rej0), .endereco_tiro(et0), .tiros_ativos(ta0),
        .num_tiros(nt0), .ocupado(oc0), .db_estado(db0)
    );

    registrador_tiros_param #(.ADDR_WIDTH(3), .DATA_WIDTH(10), .MODO_BUSCA(1)) dut1 (
        .clock(clock), .reset(rst1), .registra_tiro(r1), .dado_tiro(d1),
        .libera_tiro(l1), .libera_endereco(la1), .we_mem_tiro(we1),
        .endereco_mem_tiro(ema1), .dado_mem_tiro(dma1), .tiro_registrado(reg1),
        .tiro_rejeitado(rej1), .endereco_tiro(et1), .tiros_ativos(ta1),
        .num_tiros(nt1), .ocupado(oc1), .db_estado(db1)
    );

    // Free-running clock
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Allocation request issued at a negedge in ESPERA (cycle 0); free slot k positions from scan start
    task automatic apply_alloc(input bit sel, input logic [9:0] d, input logic [2:0] a, input int k);
        if (sel) begin r1 = 1'b1; d1 = d; end
        else     begin r0 = 1'b1; d0 = d; end
        @(negedge clock);
        r0 = 1'b0; r1 = 1'b0;
        repeat (k + 1) @(negedge clock);
        check_output("we_before_write", sel ? we1 : we0, 1'b0);
        @(negedge clock);
        check_output("we_write", sel ? we1 : we0, 1'b1);
        check_output("write_addr", sel ? ema1 : ema0, a);
        check_output("write_data", sel ? dma1 : dma0, d);
        @(negedge clock);
        check_output("registrado", sel ? reg1 : reg0, 1'b1);
        check_output("endereco_tiro", sel ? et1 : et0, a);
        @(negedge clock);
        check_output("back_to_espera", sel ? db1 : db0, 4'd1);
    endtask

    task automatic apply_release(input bit sel, input logic [2:0] a);
        if (sel) begin l1 = 1'b1; la1 = a; end
        else     begin l0 = 1'b1; la0 = a; end
        @(negedge clock);
        l0 = 1'b0; l1 = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; r0 = 1'b0; l0 = 1'b0; d0 = '0; la0 = '0;
        rst1 = 1'b1; r1 = 1'b0; l1 = 1'b0; d1 = '0; la1 = '0;
        repeat (2) @(negedge clock);
        check_output("rst_db", db0, 4'd0);
        check_output("rst_ativos", ta0, 8'h00);
        check_output("rst_num", nt0, 4'd0);
        check_output("rst_we", we0, 1'b0);
        check_output("rst_reg", reg0, 1'b0);
        check_output("rst_rej", rej0, 1'b0);
        check_output("rst_end", et0, 3'd0);
        check_output("rst_ocupado", oc0, 1'b1);
        check_output("rst_db_rr", db1, 4'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clock);
        check_output("espera_db", db0, 4'd1);
        check_output("espera_ocupado", oc0, 1'b0);
        check_output("espera_db_rr", db1, 4'd1);

        // First-free mode: fill the table from an empty start
        apply_alloc(0, 10'h155, 3'd0, 0);
        check_output("first_ativos", ta0, 8'h01);
        check_output("first_num", nt0, 4'd1);
        apply_alloc(0, 10'h101, 3'd1, 1);
        apply_alloc(0, 10'h102, 3'd2, 2);
        apply_alloc(0, 10'h103, 3'd3, 3);
        apply_alloc(0, 10'h104, 3'd4, 4);
        check_output("five_ativos", ta0, 8'h1F);
        check_output("five_num", nt0, 4'd5);
        apply_alloc(0, 10'h2AA, 3'd5, 5);
        apply_alloc(0, 10'h0C6, 3'd6, 6);
        apply_alloc(0, 10'h0C7, 3'd7, 7);
        check_output("full_ativos", ta0, 8'hFF);
        check_output("full_num", nt0, 4'd8);

        // Request on a full table is rejected at cycle 10 with no write
        r0 = 1'b1; d0 = 10'h3FF; contador = 0;
        @(negedge clock);
        r0 = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (we0 || rej0) contador++;
            @(negedge clock);
        end
        check_output("rej_pulse", rej0, 1'b1);
        check_output("rej_no_early", contador, 0);
        check_output("rej_we", we0, 1'b0);
        check_output("rej_ativos", ta0, 8'hFF);
        check_output("rej_num", nt0, 4'd8);
        @(negedge clock);
        check_output("rej_done", rej0, 1'b0);
        check_output("rej_espera", db0, 4'd1);

        // Full table, slot 6 freed while the scan sits on slot 3
        r0 = 1'b1; d0 = 10'h066;
        @(negedge clock);
        r0 = 1'b0;
        repeat (4) @(negedge clock);
        check_output("scan_verifica", db0, 4'd3);
        l0 = 1'b1; la0 = 3'd6;
        @(negedge clock);
        l0 = 1'b0;
        check_output("scan_rel_num", nt0, 4'd7);
        check_output("scan_rel_ativos", ta0, 8'hBF);
        repeat (2) @(negedge clock);
        check_output("scan_no_write_yet", we0, 1'b0);
        @(negedge clock);
        check_output("scan_we", we0, 1'b1);
        check_output("scan_addr", ema0, 3'd6);
        check_output("scan_data", dma0, 10'h066);
        @(negedge clock);
        check_output("scan_reg", reg0, 1'b1);
        check_output("scan_end", et0, 3'd6);
        check_output("scan_num", nt0, 4'd8);
        check_output("scan_ativos", ta0, 8'hFF);
        @(negedge clock);

        // Free slot 2, then SALVA on slot 2 coincides with release of slot 5
        apply_release(0, 3'd2);
        check_output("rel2_ativos", ta0, 8'hFB);
        check_output("rel2_num", nt0, 4'd7);
        r0 = 1'b1; d0 = 10'h0F0;
        @(negedge clock);
        r0 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        r0 = 1'b1;
        @(negedge clock);
        r0 = 1'b0;
        @(negedge clock);
        check_output("same_we", we0, 1'b1);
        check_output("same_addr", ema0, 3'd2);
        check_output("same_data", dma0, 10'h0F0);
        l0 = 1'b1; la0 = 3'd5;
        @(negedge clock);
        l0 = 1'b0;
        check_output("same_reg", reg0, 1'b1);
        check_output("same_end", et0, 3'd2);
        check_output("same_ativos", ta0, 8'hDF);
        check_output("same_num", nt0, 4'd7);
        contador = 0;
        for (int c = 7; c <= 12; c++) begin
            @(negedge clock);
            if (we0 || reg0 || rej0) contador++;
        end
        check_output("ignored_req", contador, 0);
        check_output("ignored_espera", db0, 4'd1);

        // Releasing a free slot is a no-op; then trim down to slots 0-3
        apply_release(0, 3'd5);
        check_output("noop_num", nt0, 4'd7);
        check_output("noop_ativos", ta0, 8'hDF);
        apply_release(0, 3'd4);
        apply_release(0, 3'd6);
        apply_release(0, 3'd7);
        check_output("four_ativos", ta0, 8'h0F);
        check_output("four_num", nt0, 4'd4);

        // Reset asserted during VERIFICA aborts the allocation
        r0 = 1'b1; d0 = 10'h1E1;
        @(negedge clock);
        r0 = 1'b0;
        repeat (2) @(negedge clock);
        check_output("mid_verifica", db0, 4'd3);
        rst0 = 1'b1;
        @(negedge clock);
        rst0 = 1'b0;
        check_output("mid_rst_db", db0, 4'd0);
        check_output("mid_rst_ativos", ta0, 8'h00);
        check_output("mid_rst_num", nt0, 4'd0);
        check_output("mid_rst_we", we0, 1'b0);
        check_output("mid_rst_reg", reg0, 1'b0);
        @(negedge clock);
        check_output("mid_rst_espera", db0, 4'd1);
        contador = 0;
        for (int c = 5; c <= 9; c++) begin
            if (we0 || reg0) contador++;
            @(negedge clock);
        end
        check_output("mid_rst_quiet", contador, 0);

        // Round-robin mode: allocation continues after the last slot, then wraps
        apply_alloc(1, 10'h011, 3'd0, 0);
        apply_alloc(1, 10'h022, 3'd1, 0);
        apply_alloc(1, 10'h033, 3'd2, 0);
        apply_release(1, 3'd0);
        check_output("rr_rel_ativos", ta1, 8'h06);
        check_output("rr_rel_num", nt1, 4'd2);
        apply_alloc(1, 10'h044, 3'd3, 0);
        check_output("rr_skip_ativos", ta1, 8'h0E);
        apply_alloc(1, 10'h055, 3'd4, 0);
        apply_alloc(1, 10'h066, 3'd5, 0);
        apply_alloc(1, 10'h077, 3'd6, 0);
        apply_alloc(1, 10'h088, 3'd7, 0);
        check_output("rr_seven_ativos", ta1, 8'hFE);
        check_output("rr_seven_num", nt1, 4'd7);
        apply_alloc(1, 10'h0AA, 3'd0, 0);
        check_output("rr_wrap_ativos", ta1, 8'hFF);
        check_output("rr_wrap_num", nt1, 4'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/registrador_tiros_param.md
Name: registrador_tiros_param

Overview:
Parametrised shot-slot allocator for the shot subsystem. It owns the per-slot "loaded" flags for an N-slot shot memory and latches the shot word (ship position + opcode) on request. It scans for a free slot, first-free or round-robin per mode, and writes the word through the external shot-memory write port. It also frees slots on request from the collision/expiry logic and reports full, occupancy and debug state to the game control unit.

Parameters:
ADDR_WIDTH, 3, slot address width; N_TIROS = 2**ADDR_WIDTH slots
DATA_WIDTH, 10, width of the shot word written to memory
MODO_BUSCA, 0, 0 = scan starts at slot 0 every time; 1 = round-robin, scan starts at slot after last allocated

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
registra_tiro  in  1  request allocation; sampled only in ESPERA
dado_tiro  in  DATA_WIDTH  shot word; latched in the cycle registra_tiro is accepted
libera_tiro  in  1  free slot libera_endereco this cycle
libera_endereco  in  ADDR_WIDTH  slot to free
we_mem_tiro  out  1  shot-memory write enable
endereco_mem_tiro  out  ADDR_WIDTH  shot-memory write address
dado_mem_tiro  out  DATA_WIDTH  shot-memory write data (latched word)
tiro_registrado  out  1  1-cycle pulse: allocation succeeded
tiro_rejeitado  out  1  1-cycle pulse: all slots loaded, request dropped
endereco_tiro  out  ADDR_WIDTH  slot allocated by the last successful request; held until the next one
tiros_ativos  out  N_TIROS  loaded flag per slot
num_tiros  out  ADDR_WIDTH+1  count of loaded slots
ocupado  out  1  high whenever state != ESPERA
db_estado  out  4  debug state code

Behaviour:
- Reset (synchronous): state INICIAL. tiros_ativos, num_tiros, endereco_tiro, round-robin pointer, scan pointer, scan counter and latched word all clear to 0. we_mem_tiro, tiro_registrado and tiro_rejeitado are 0. Reset mid-scan aborts with no write and no pulse.
- States and db codes: INICIAL 0, ESPERA 1, ZERA 2, VERIFICA 3, SALVA 5, SINALIZA 6, CHEIO 8. Any other encoding goes to INICIAL, db F.
- INICIAL -> ESPERA unconditionally.
- ESPERA: if registra_tiro, latch dado_tiro -> ZERA; else stay.
- ZERA: scan pointer = 0 (MODO_BUSCA=0) or round-robin pointer (MODO_BUSCA=1); scan counter = 0 -> VERIFICA.
- VERIFICA, one slot per cycle:
  - If tiros_ativos[ptr]==0 -> SALVA.
  - Else if scan counter == N_TIROS-1 -> CHEIO.
  - Else ptr = ptr+1 mod N_TIROS (wraps), counter+1, stay.
- SALVA: we_mem_tiro=1, endereco_mem_tiro=ptr, dado_mem_tiro=latched word. Set tiros_ativos[ptr]; endereco_tiro=ptr; round-robin pointer = ptr+1 mod N_TIROS -> SINALIZA.
- SINALIZA: tiro_registrado=1 -> ESPERA.
- CHEIO: tiro_rejeitado=1; no write; pointers unchanged -> ESPERA.
- Latency: request accepted in ESPERA at cycle 0, first free slot k positions from scan start:
  - Success: write in cycle 3+k, tiro_registrado in cycle 4+k.
  - Full: tiro_rejeitado in cycle N_TIROS+2.
- registra_tiro outside ESPERA is ignored, not queued. It is accepted again in the cycle following SINALIZA/CHEIO (the ESPERA cycle).
- Release:
  - Accepted in every state except INICIAL and during reset.
  - Clears tiros_ativos[libera_endereco] at the clock edge.
  - Releasing an already-free slot is a no-op; num_tiros does not change.
  - A slot released during a scan becomes visible to VERIFICA in the next cycle. A slot already passed in the current scan is not revisited.
- Simultaneous SALVA set and release:
  - Same slot: set wins. The slot is free, so the release is a no-op.
  - Different slots: both apply; num_tiros unchanged.
- num_tiros: registered up/down counter, +1 on SALVA, -1 on effective release. It must always equal popcount(tiros_ativos) and never exceeds N_TIROS.
- dado_mem_tiro and endereco_mem_tiro may hold stale values when we_mem_tiro=0.

Test Plan:
- Default params, empty. registra_tiro=1 with dado_tiro=0x155 at cycle 0 -> we_mem_tiro=1, addr 0, data 0x155 at cycle 3; tiro_registrado at cycle 4; tiros_ativos=0x01; num_tiros=1.
- MODO_BUSCA=0, slots 0-4 loaded -> write at addr 5 in cycle 8, pulse in cycle 9. Then 2 more allocations give addrs 6, 7. A 9th request gives tiro_rejeitado at cycle 10, no write, tiros_ativos=0xFF.
- MODO_BUSCA=1. Allocate 0, 1, 2; release 0; allocate -> addr 3, not 0. Fill to slot 7, then the next allocation wraps to addr 0.
- Full table, scan in progress with ptr=3; release slot 6 in that cycle -> allocation lands at addr 6; num_tiros returns to 8.
- Same-cycle SALVA on slot 2 and release of slot 5 (loaded) -> tiros_ativos bit 2 set, bit 5 cleared, num_tiros unchanged. registra_tiro pulsed during the scan -> ignored, exactly one allocation.
- Reset asserted mid-VERIFICA with 4 slots loaded -> next cycle state INICIAL; tiros_ativos=0, num_tiros=0, no write, no pulse. ESPERA one cycle later.
